// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU result producer, the capture FIFO and its consumer.
// The FIFO binds to the slave modport; the producer/consumer side binds to master.
interface alu_result_fifo_if #(
  parameter int DATA_W = 7,
  parameter int CNT_W  = 3
);
  // Valid/ready: a transfer happens on a rising edge where both valid and ready are 1;
  // valid never waits on ready, and payload is held stable while valid=1 and ready=0.
  logic              in_valid;
  logic [DATA_W-1:0] R;
  logic              CF;
  logic              SF;
  logic              ZF;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_R;
  logic              out_CF;
  logic              out_SF;
  logic              out_ZF;
  logic [CNT_W-1:0]  count;
  logic              ovf;

  modport slave (
    input  in_valid, R, CF, SF, ZF, out_ready,
    output in_ready, out_valid, out_R, out_CF, out_SF, out_ZF, count, ovf
  );

  modport master (
    output in_valid, R, CF, SF, ZF, out_ready,
    input  in_ready, out_valid, out_R, out_CF, out_SF, out_ZF, count, ovf
  );
endinterface

// File: rtl/alu_result_fifo.sv
// Synchronous FIFO capturing {R, CF, SF, ZF} ALU results with a sticky overflow flag.
// Optional sticky flag outputs are enabled by defining ALU_RESULT_FIFO_STICKY_FLAGS_EN.
module alu_result_fifo #(
  parameter int DATA_W = 7,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  alu_result_fifo_if.slave bus
`ifdef ALU_RESULT_FIFO_STICKY_FLAGS_EN
  ,
  output logic sticky_CF,
  output logic sticky_SF,
  output logic sticky_ZF
`endif
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = DATA_W + 3;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovf;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_wr_entry;
  logic [ENTRY_W-1:0] w_head;

  assign w_in_ready  = (r_count != CNT_W'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid & w_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready;
  assign w_wr_entry  = {bus.R, bus.CF, bus.SF, bus.ZF};

  // Head is masked to zero when empty so stale storage never leaks out.
  assign w_head = w_out_valid ? r_mem[r_rd_ptr] : '0;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_R     = w_head[ENTRY_W-1:3];
  assign bus.out_CF    = w_head[2];
  assign bus.out_SF    = w_head[1];
  assign bus.out_ZF    = w_head[0];
  assign bus.count     = r_count;
  assign bus.ovf       = r_ovf;

  always_ff @(posedge clk) begin
    if (rst_n && !clr && w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // in_ready is from the pre-edge count, so a pop this cycle does not rescue the entry.
      if (bus.in_valid && !w_in_ready) begin
        r_ovf <= 1'b1;
      end
    end
  end

`ifdef ALU_RESULT_FIFO_STICKY_FLAGS_EN
  logic r_sticky_cf;
  logic r_sticky_sf;
  logic r_sticky_zf;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_sticky_cf <= 1'b0;
      r_sticky_sf <= 1'b0;
      r_sticky_zf <= 1'b0;
    end else if (w_push) begin
      r_sticky_cf <= r_sticky_cf | bus.CF;
      r_sticky_sf <= r_sticky_sf | bus.SF;
      r_sticky_zf <= r_sticky_zf | bus.ZF;
    end
  end

  assign sticky_CF = r_sticky_cf;
  assign sticky_SF = r_sticky_sf;
  assign sticky_ZF = r_sticky_zf;
`endif
endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed-vector bench for alu_result_fifo: driver tasks push expected entries into a
// scoreboard queue, a negedge monitor pops and compares on every consumer handshake.
module tb_alu_result_fifo;
  localparam int DATA_W  = 7;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 3;
  localparam int ENTRY_W = DATA_W + 3;

  logic clk;
  logic rst_n;
  logic clr;

  alu_result_fifo_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

`ifdef ALU_RESULT_FIFO_STICKY_FLAGS_EN
  logic sticky_CF;
  logic sticky_SF;
  logic sticky_ZF;
`endif

  alu_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
`ifdef ALU_RESULT_FIFO_STICKY_FLAGS_EN
    ,
    .sticky_CF (sticky_CF),
    .sticky_SF (sticky_SF),
    .sticky_ZF (sticky_ZF)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [ENTRY_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int m_count  = 0;
  bit m_ovf    = 1'b0;
  bit m_scf    = 1'b0;
  bit m_ssf    = 1'b0;
  bit m_szf    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1 && clr === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL pop_unexpected: got %0h expected none",
                 {bus.out_R, bus.out_CF, bus.out_SF, bus.out_ZF});
      end else begin
        logic [ENTRY_W-1:0] e;
        logic [ENTRY_W-1:0] a;
        e = exp_q.pop_front();
        a = {bus.out_R, bus.out_CF, bus.out_SF, bus.out_ZF};
        if (a === e) n_pass++;
        else $display("FAIL pop_data: got %0h expected %0h", a, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; the bench model predicts the response independently.
  task automatic cycle(input bit iv, input logic [DATA_W-1:0] r, input bit cf, input bit sf,
                       input bit zf, input bit ordy, input bit c);
    bit pop;
    bit push;
    bus.in_valid  = iv;
    bus.R         = r;
    bus.CF        = cf;
    bus.SF        = sf;
    bus.ZF        = zf;
    bus.out_ready = ordy;
    clr           = c;
    if (c) begin
      exp_q.delete();
      m_count = 0;
      m_ovf   = 1'b0;
      m_scf   = 1'b0;
      m_ssf   = 1'b0;
      m_szf   = 1'b0;
    end else begin
      push = iv && (m_count != DEPTH);
      pop  = ordy && (m_count != 0);
      if (iv && m_count == DEPTH) m_ovf = 1'b1;
      if (push) begin
        exp_q.push_back({r, cf, sf, zf});
        m_scf = m_scf | cf;
        m_ssf = m_ssf | sf;
        m_szf = m_szf | zf;
      end
      m_count = m_count + int'(push) - int'(pop);
    end
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    clr           = 1'b0;
  endtask

  task automatic push_one(input logic [DATA_W-1:0] r);
    cycle(1'b1, r, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input bit ordy);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    clr           = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_q.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_scf   = 1'b0;
    m_ssf   = 1'b0;
    m_szf   = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_count"},     32'(bus.count),     32'(m_count));
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(m_count != 0));
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'(m_count != DEPTH));
    chk({tag, "_ovf"},       32'(bus.ovf),       32'(m_ovf));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.R  = '0;
    bus.CF = 1'b0;
    bus.SF = 1'b0;
    bus.ZF = 1'b0;
    do_reset();

    // reset state
    check_status("reset");
    chk("reset_out_R", 32'(bus.out_R), 32'h0);
    chk("reset_out_flags", 32'({bus.out_CF, bus.out_SF, bus.out_ZF}), 32'h0);

    // single entry, visible one edge after push
    cycle(1'b1, 7'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("single_count", 32'(bus.count), 32'd1);
    chk("single_out_valid", 32'(bus.out_valid), 32'd1);
    chk("single_out_R", 32'(bus.out_R), 32'h55);
    chk("single_flags", 32'({bus.out_CF, bus.out_SF, bus.out_ZF}), 32'b110);
    idle(1'b1);
    chk("single_pop_count", 32'(bus.count), 32'd0);
    chk("single_pop_valid", 32'(bus.out_valid), 32'd0);

    // fill to full, overflow drop, drain in order
    for (int i = 1; i <= 4; i++) push_one(7'(i));
    chk("full_count", 32'(bus.count), 32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    push_one(7'h05);
    chk("ovf_set", 32'(bus.ovf), 32'd1);
    chk("ovf_count", 32'(bus.count), 32'd4);
    for (int i = 0; i < 4; i++) idle(1'b1);
    check_status("drained");
    idle(1'b1);
    chk("ovf_sticky", 32'(bus.ovf), 32'd1);

    // simultaneous push/pop at count=2, then across pointer wrap
    push_one(7'h0e);
    push_one(7'h0f);
    cycle(1'b1, 7'h10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("simul_count", 32'(bus.count), 32'd2);
    chk("simul_head", 32'(bus.out_R), 32'h0f);
    for (int i = 0; i < 8; i++) cycle(1'b1, 7'(8'h20 + i), i[0], i[1], i[2], 1'b1, 1'b0);
    check_status("stream");
    idle(1'b1);
    idle(1'b1);
    check_status("stream_drain");

    // backpressure keeps head stable
    push_one(7'h33);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      chk("hold_out_R", 32'(bus.out_R), 32'h33);
      chk("hold_count", 32'(bus.count), 32'd1);
    end
    idle(1'b1);
    check_status("hold_drain");

    // clr beats a same-cycle push and pop
    push_one(7'h61);
    push_one(7'h62);
    push_one(7'h63);
    chk("pre_clr_count", 32'(bus.count), 32'd3);
    chk("pre_clr_ovf", 32'(bus.ovf), 32'd1);
    cycle(1'b1, 7'h7f, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_count", 32'(bus.count), 32'd0);
    chk("clr_ovf", 32'(bus.ovf), 32'd0);
    chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
    idle(1'b1);
    chk("clr_no_entry", 32'(bus.out_valid), 32'd0);
    chk("clr_out_R_zero", 32'(bus.out_R), 32'h0);

    // full with pop in the same cycle still drops the incoming entry
    for (int i = 0; i < 4; i++) push_one(7'(8'h41 + i));
    cycle(1'b1, 7'h4f, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("full_pop_ovf", 32'(bus.ovf), 32'd1);
    chk("full_pop_count", 32'(bus.count), 32'd3);
    for (int i = 0; i < 3; i++) idle(1'b1);
    check_status("full_pop_drain");

`ifdef ALU_RESULT_FIFO_STICKY_FLAGS_EN
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 7'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 7'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sticky_zf", 32'(sticky_ZF), 32'(m_szf));
    chk("sticky_sf", 32'(sticky_SF), 32'(m_ssf));
    chk("sticky_cf", 32'(sticky_CF), 32'(m_scf));
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sticky_clr", 32'({sticky_CF, sticky_SF, sticky_ZF}), 32'h0);
`endif

    // reset mid-operation loses buffered entries
    push_one(7'h11);
    push_one(7'h22);
    do_reset();
    check_status("midreset");
    chk("midreset_out_R", 32'(bus.out_R), 32'h0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
